// File: rtl/whack_vga_pkg.sv
// whack_vga_pkg: shared screen geometry, colour codes and arbiter state encoding
package whack_vga_pkg;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam logic [2:0] BLACK   = 3'd0;
  localparam logic [2:0] BLUE    = 3'd1;
  localparam logic [2:0] GREEN   = 3'd2;
  localparam logic [2:0] CYAN    = 3'd3;
  localparam logic [2:0] RED     = 3'd4;
  localparam logic [2:0] MAGENTA = 3'd5;
  localparam logic [2:0] YELLOW  = 3'd6;
  localparam logic [2:0] WHITE   = 3'd7;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRAW = 2'd1,
    ST_DONE = 2'd2
  } arb_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first set request at or above ptr with wrap
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic          valid
);
  logic [N-1:0] rot, low;
  logic [2*N-1:0] back;
  always_comb begin
    rot = N'({req, req} >> ptr);
    low = rot & -rot;
    back = {{N{1'b0}}, low} << ptr;
    win = back[N-1:0] | back[2*N-1:N];
    valid = |req;
  end
endmodule

// File: rtl/vga_rect_arbiter.sv
// vga_rect_arbiter: round-robin owner of the VGA pixel port, fills one clipped rectangle per grant
module vga_rect_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int SCREEN_W = whack_vga_pkg::SCREEN_W,
  parameter int SCREEN_H = whack_vga_pkg::SCREEN_H,
  parameter int DIM_W    = 5
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*8-1:0]     req_x,
  input  logic [NUM_REQ*7-1:0]     req_y,
  input  logic [NUM_REQ*DIM_W-1:0] req_w,
  input  logic [NUM_REQ*DIM_W-1:0] req_h,
  input  logic [NUM_REQ*3-1:0]     req_color,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic [7:0]               VGA_X,
  output logic [6:0]               VGA_Y,
  output logic [2:0]               VGA_COLOR,
  output logic                     plot
);
  localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  whack_vga_pkg::arb_state_t state;
  logic [PW-1:0] ptr, owner, sel_owner;
  logic [NUM_REQ-1:0] win;
  logic valid;
  logic [7:0] x0, sel_x, bx;
  logic [6:0] y0, sel_y, by;
  logic [DIM_W-1:0] w_q, h_q, sel_w, sel_h, cx, cy, nx, ny;
  logic [2:0] col_q, sel_c, bc;
  logic [8:0] sx;
  logic [7:0] sy;
  logic idle, last_col, last, adv, vis;
  rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_rr (
    .req(req),
    .ptr(ptr),
    .win(win),
    .valid(valid)
  );
  always_comb begin
    sel_owner = '0;
    sel_x = '0;
    sel_y = '0;
    sel_w = '0;
    sel_h = '0;
    sel_c = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (win[i]) begin
        sel_owner = PW'(i);
        sel_x = req_x[8*i +: 8];
        sel_y = req_y[7*i +: 7];
        sel_w = req_w[DIM_W*i +: DIM_W];
        sel_h = req_h[DIM_W*i +: DIM_W];
        sel_c = req_color[3*i +: 3];
      end
    idle = state == whack_vga_pkg::ST_IDLE;
    last_col = cx == w_q - DIM_W'(1);
    // an empty rectangle still spends its grant cycle in DRAW so done lands one cycle later
    last = w_q == '0 || h_q == '0 || (last_col && cy == h_q - DIM_W'(1));
    adv = idle ? valid : state == whack_vga_pkg::ST_DRAW && !last;
    nx = idle || last_col ? '0 : cx + DIM_W'(1);
    ny = idle ? '0 : last_col ? cy + DIM_W'(1) : cy;
    bx = idle ? sel_x : x0;
    by = idle ? sel_y : y0;
    bc = idle ? sel_c : col_q;
    sx = 9'(bx) + 9'(nx);
    sy = 8'(by) + 8'(ny);
    vis = !(idle && (sel_w == '0 || sel_h == '0)) && sx < 9'(SCREEN_W) && sy < 8'(SCREEN_H);
  end
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) begin
      state <= whack_vga_pkg::ST_IDLE;
      ptr <= '0;
      owner <= '0;
      x0 <= '0;
      y0 <= '0;
      w_q <= '0;
      h_q <= '0;
      col_q <= '0;
      cx <= '0;
      cy <= '0;
      gnt <= '0;
      done <= '0;
      busy <= 1'b0;
      plot <= 1'b0;
      VGA_X <= '0;
      VGA_Y <= '0;
      VGA_COLOR <= whack_vga_pkg::BLACK;
    end else begin
      gnt <= '0;
      done <= '0;
      plot <= adv && vis;
      if (adv) begin
        cx <= nx;
        cy <= ny;
      end
      if (adv && vis) begin
        VGA_X <= sx[7:0];
        VGA_Y <= sy[6:0];
        VGA_COLOR <= bc;
      end
      case (state)
        whack_vga_pkg::ST_IDLE:
          if (valid) begin
            state <= whack_vga_pkg::ST_DRAW;
            owner <= sel_owner;
            x0 <= sel_x;
            y0 <= sel_y;
            w_q <= sel_w;
            h_q <= sel_h;
            col_q <= sel_c;
            gnt <= win;
            busy <= 1'b1;
          end
        whack_vga_pkg::ST_DRAW:
          if (last) begin
            state <= whack_vga_pkg::ST_DONE;
            done <= NUM_REQ'(1) << owner;
            ptr <= owner == PW'(NUM_REQ - 1) ? '0 : owner + PW'(1);
          end
        default: begin
          state <= whack_vga_pkg::ST_IDLE;
          busy <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_vga_rect_arbiter.sv
// tb_vga_rect_arbiter: directed and random rectangle requests checked against a frame-queue model
module tb_vga_rect_arbiter;
  localparam int N = 4;
  localparam int D = 5;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [N*8-1:0] req_x = '0;
  logic [N*7-1:0] req_y = '0;
  logic [N*D-1:0] req_w = '0, req_h = '0;
  logic [N*3-1:0] req_color = '0;
  logic [N-1:0] gnt, done;
  logic busy, plot;
  logic [7:0] VGA_X;
  logic [6:0] VGA_Y;
  logic [2:0] VGA_COLOR;
  always #5 clk = ~clk;
  vga_rect_arbiter #(.NUM_REQ(N), .SCREEN_W(160), .SCREEN_H(120), .DIM_W(D)) dut (
    .CLOCK_50(clk),
    .reset(rst),
    .req(req),
    .req_x(req_x),
    .req_y(req_y),
    .req_w(req_w),
    .req_h(req_h),
    .req_color(req_color),
    .gnt(gnt),
    .done(done),
    .busy(busy),
    .VGA_X(VGA_X),
    .VGA_Y(VGA_Y),
    .VGA_COLOR(VGA_COLOR),
    .plot(plot)
  );
  typedef struct {
    logic [N-1:0] g;
    logic [N-1:0] d;
    logic b;
    logic p;
    int x;
    int y;
    int c;
  } frame_t;
  frame_t q[$];
  int mptr = 0;
  logic [N-1:0] e_g = '0, e_d = '0;
  logic e_b = 1'b0, e_p = 1'b0;
  int lx = 0, ly = 0, lc = 0;
  int errors = 0, checks = 0;
  logic [17:0] pix[$];
  // Model: each grant expands into one expected output frame per cycle (pixels, done, idle gap)
  always @(posedge clk) begin : model
    frame_t f;
    int win;
    if (rst) begin
      q.delete();
      mptr = 0;
      e_g = '0;
      e_d = '0;
      e_b = 1'b0;
      e_p = 1'b0;
      lx = 0;
      ly = 0;
      lc = 0;
    end else begin
      if (q.size() == 0) begin
        win = -1;
        for (int k = 0; k < N; k++)
          if (win < 0 && req[(mptr + k) % N]) win = (mptr + k) % N;
        if (win >= 0) begin
          int x, y, w, h, c, n;
          x = int'(req_x[8*win +: 8]);
          y = int'(req_y[7*win +: 7]);
          w = int'(req_w[D*win +: D]);
          h = int'(req_h[D*win +: D]);
          c = int'(req_color[3*win +: 3]);
          n = (w == 0 || h == 0) ? 1 : w * h;
          for (int k = 0; k < n; k++) begin
            f.g = k == 0 ? N'(1) << win : '0;
            f.d = '0;
            f.b = 1'b1;
            f.x = w > 0 ? x + k % w : x;
            f.y = w > 0 ? y + k / w : y;
            f.c = c;
            f.p = w > 0 && h > 0 && f.x < 160 && f.y < 120;
            q.push_back(f);
          end
          f.g = '0;
          f.d = N'(1) << win;
          f.p = 1'b0;
          q.push_back(f);
          f.d = '0;
          f.b = 1'b0;
          q.push_back(f);
          mptr = (win + 1) % N;
        end
      end
      if (q.size() > 0) f = q.pop_front();
      else begin
        f.g = '0;
        f.d = '0;
        f.b = 1'b0;
        f.p = 1'b0;
      end
      e_g = f.g;
      e_d = f.d;
      e_b = f.b;
      e_p = f.p;
      if (f.p) begin
        lx = f.x;
        ly = f.y;
        lc = f.c;
      end
    end
  end
  always @(negedge clk) begin
    checks++;
    if ({gnt, done, busy, plot} !== {e_g, e_d, e_b, e_p} || VGA_X !== 8'(lx) || VGA_Y !== 7'(ly) || VGA_COLOR !== 3'(lc)) begin
      errors++;
      $display("FAIL cycle_model t=%0t got gnt=%b done=%b busy=%b plot=%b xyc=%0d,%0d,%0d want gnt=%b done=%b busy=%b plot=%b xyc=%0d,%0d,%0d",
               $time, gnt, done, busy, plot, VGA_X, VGA_Y, VGA_COLOR, e_g, e_d, e_b, e_p, lx, ly, lc);
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask
  task automatic set_c(input int i, input int x, input int y, input int w, input int h, input int c);
    req_x[8*i +: 8] = 8'(x);
    req_y[7*i +: 7] = 7'(y);
    req_w[D*i +: D] = D'(w);
    req_h[D*i +: D] = D'(h);
    req_color[3*i +: 3] = 3'(c);
  endtask
  task automatic rnd(input int i);
    set_c(i, $urandom_range(0, 3) == 0 ? $urandom_range(140, 255) : $urandom_range(0, 159),
          $urandom_range(0, 3) == 0 ? $urandom_range(110, 127) : $urandom_range(0, 119),
          $urandom_range(0, 15) == 0 ? 31 : $urandom_range(0, 6),
          $urandom_range(0, 15) == 0 ? 31 : $urandom_range(0, 6),
          $urandom_range(0, 7));
  endtask
  task automatic watch(output logic [N-1:0] g, output logic [N-1:0] d, output int tg, output int td, output int nb);
    g = '0;
    d = '0;
    tg = -1;
    td = -1;
    nb = 0;
    pix.delete();
    for (int t = 0; t < 3000 && d == '0; t++) begin
      @(negedge clk);
      if (gnt != '0 && tg < 0) begin
        g = gnt;
        tg = t;
      end
      req = req & ~gnt;
      nb += int'(busy);
      if (plot) pix.push_back({VGA_X, VGA_Y, VGA_COLOR});
      if (done != '0) begin
        d = done;
        td = t;
      end
    end
  endtask
  task automatic drain();
    req = '0;
    for (int t = 0; t < 3000 && busy; t++) @(negedge clk);
    repeat (2) @(negedge clk);
  endtask
  initial begin
    logic [N-1:0] g, d;
    int tg, td, nb;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({gnt, done, busy, plot, VGA_X, VGA_Y, VGA_COLOR}), 32'd0);
    #1 rst = 1'b0;
    set_c(1, 10, 20, 3, 2, 5);
    req[1] = 1'b1;
    watch(g, d, tg, td, nb);
    chk("t1_gnt", 32'(g), 32'b0010);
    chk("t1_gnt_time", tg, 0);
    chk("t1_plots", pix.size(), 6);
    chk("t1_pix0", 32'(pix[0]), 32'({8'd10, 7'd20, 3'd5}));
    chk("t1_pix3", 32'(pix[3]), 32'({8'd10, 7'd21, 3'd5}));
    chk("t1_pix5", 32'(pix[5]), 32'({8'd12, 7'd21, 3'd5}));
    chk("t1_done", 32'(d), 32'b0010);
    chk("t1_done_time", td, 6);
    drain();
    #1 rst = 1'b1;
    set_c(0, 30, 40, 2, 1, 3);
    set_c(2, 50, 60, 1, 2, 4);
    req = 4'b0101;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    watch(g, d, tg, td, nb);
    chk("t2_first", 32'(g), 32'b0001);
    watch(g, d, tg, td, nb);
    chk("t2_second", 32'(g), 32'b0100);
    req[0] = 1'b1;
    watch(g, d, tg, td, nb);
    chk("t2_wrap", 32'(g), 32'b0001);
    drain();
    set_c(3, 158, 119, 4, 2, 6);
    req[3] = 1'b1;
    watch(g, d, tg, td, nb);
    chk("t3_plots", pix.size(), 2);
    chk("t3_pix0", 32'(pix[0]), 32'({8'd158, 7'd119, 3'd6}));
    chk("t3_pix1", 32'(pix[1]), 32'({8'd159, 7'd119, 3'd6}));
    chk("t3_len", td - tg, 8);
    chk("t3_busy", nb, 9);
    drain();
    set_c(1, 5, 5, 0, 7, 2);
    req[1] = 1'b1;
    watch(g, d, tg, td, nb);
    chk("t4_plots", pix.size(), 0);
    chk("t4_len", td - tg, 1);
    chk("t4_busy", nb, 2);
    chk("t4_done", 32'(d), 32'b0010);
    drain();
    set_c(2, 0, 0, 4, 4, 1);
    req = 4'b0100;
    for (int t = 0; t < 50 && gnt == '0; t++) @(negedge clk);
    chk("t5_gnt", 32'(gnt), 32'b0100);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    req = 4'b1010;
    set_c(1, 1, 1, 1, 1, 7);
    set_c(3, 2, 2, 1, 1, 3);
    #1 chk("t5_async_clear", 32'({gnt, done, busy, plot}), 32'd0);
    repeat (2) @(negedge clk);
    chk("t5_no_done", 32'(done), 32'd0);
    #1 rst = 1'b0;
    watch(g, d, tg, td, nb);
    chk("t5_ptr_reset", 32'(g), 32'b0010);
    drain();
    for (int cyc = 0; cyc < 5000; cyc++) begin
      @(negedge clk);
      #1;
      if (cyc == 2500) rst = 1'b1;
      if (cyc == 2503) rst = 1'b0;
      for (int i = 0; i < N; i++)
        if (gnt[i]) begin
          rnd(i);
          req[i] = 1'($urandom_range(0, 1));
        end else if (!req[i] && $urandom_range(0, 3) == 0) begin
          rnd(i);
          req[i] = 1'b1;
        end else if (req[i] && $urandom_range(0, 40) == 0) req[i] = 1'b0;
    end
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
